tcdm_bank_req_arbiter: RTL and testbench

//  Sits directly upstream of one bank's atomic/LR-SC adapter: merges NumInPorts valid/ready

---
 rtl/tcdm_bank_req_arbiter_pkg.sv | 21 ++
 rtl/tcdm_bank_req_arbiter_fifo.sv | 82 ++++++++
 rtl/tcdm_bank_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tcdm_bank_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tcdm_bank_req_arbiter_pkg
//   Shared helpers for the bank request arbiter and its port-ID FIFO.
//   - idx_width(): bits needed to index num_idx items (at least 1 bit)
//   - rr_next()  : round-robin successor of an index, wrapping at num_idx
// -----------------------------------------------------------------------------
package tcdm_bank_req_arbiter_pkg;

   // Index width for a set of num_idx elements; a single element still
   // needs one bit so that the index signal is never zero-width.
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

   // Successor of idx in a ring of num_idx slots.
   function automatic int unsigned rr_next(input int unsigned idx,
                                           input int unsigned num_idx);
      return (idx + 32'd1 >= num_idx) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/tcdm_bank_req_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// tcdm_bank_req_arbiter_fifo
//   Non-fall-through FIFO holding the port IDs of accepted requests so that
//   responses can be routed back in order. A pushed entry is visible at the
//   head only from the cycle after the push.
// Ports
//   clk_i    in   clock
//   rst_ni   in   asynchronous reset, active low (empties the FIFO)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   port ID to store
//   pop_i    in   drop the head entry (ignored when empty)
//   data_o   out  head entry
//   full_o   out  Depth entries stored
//   empty_o  out  no entries stored
// -----------------------------------------------------------------------------
module tcdm_bank_req_arbiter_fifo
   import tcdm_bank_req_arbiter_pkg::*;
#(
   parameter int unsigned DataWidth = 2,
   parameter int unsigned Depth     = 4   // power of 2, >= 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned PtrWidth = idx_width(Depth);

   logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrWidth:0]    count_q,  count_d;
   logic [DataWidth-1:0] mem_q [Depth];
   logic                 push_en, pop_en;

   assign full_o  = (count_q == (PtrWidth+1)'(Depth));
   assign empty_o = (count_q == '0);
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i  && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // NOTE: every combinational output gets a default before any condition,
   //       so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Depth is a power of 2, so the pointers wrap naturally.
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;   // idle or push+pop: occupancy unchanged
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only read
   //       after it was written, and the pointers/count carry the reset state.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/tcdm_bank_req_arbiter.sv
// -----------------------------------------------------------------------------
// tcdm_bank_req_arbiter
//   Merges NumInPorts valid/ready request ports into one bank request port
//   with round-robin arbitration, and routes each bank response back to the
//   port that issued the matching request (responses return in order).
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       per-port request handshake
//   in_address_i, in_amo_i, in_write_i, in_wdata_i, in_be_i, in_meta_i
//                                 per-port request payload
//   in_valid_o / in_ready_i       per-port response handshake
//   in_rdata_o, in_meta_o         response payload, broadcast to all ports
//   out_valid_o / out_ready_i     bank request handshake
//   out_address_o ... out_meta_o  bank request payload (winner's fields)
//   out_valid_i / out_ready_o     bank response handshake
//   out_rdata_i, out_meta_i       bank response payload
// -----------------------------------------------------------------------------
module tcdm_bank_req_arbiter
   import tcdm_bank_req_arbiter_pkg::*;
#(
   parameter int unsigned NumInPorts    = 4,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter type         metadata_t    = logic,
   parameter int unsigned RespFifoDepth = 4,
   localparam int unsigned BeWidth      = DataWidth / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // request side, per port
   input  logic [NumInPorts-1:0] in_valid_i,
   output logic [NumInPorts-1:0] in_ready_o,
   input  logic [AddrWidth-1:0]  in_address_i [NumInPorts],
   input  logic [3:0]            in_amo_i     [NumInPorts],
   input  logic [NumInPorts-1:0] in_write_i,
   input  logic [DataWidth-1:0]  in_wdata_i   [NumInPorts],
   input  logic [BeWidth-1:0]    in_be_i      [NumInPorts],
   input  metadata_t             in_meta_i    [NumInPorts],
   // response side, per port
   output logic [NumInPorts-1:0] in_valid_o,
   input  logic [NumInPorts-1:0] in_ready_i,
   output logic [DataWidth-1:0]  in_rdata_o   [NumInPorts],
   output metadata_t             in_meta_o    [NumInPorts],
   // bank request
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [AddrWidth-1:0]  out_address_o,
   output logic [3:0]            out_amo_o,
   output logic                  out_write_o,
   output logic [DataWidth-1:0]  out_wdata_o,
   output logic [BeWidth-1:0]    out_be_o,
   output metadata_t             out_meta_o,
   // bank response
   input  logic                  out_valid_i,
   output logic                  out_ready_o,
   input  logic [DataWidth-1:0]  out_rdata_i,
   input  metadata_t             out_meta_i
);

   localparam int unsigned IdxWidth = idx_width(NumInPorts);
   typedef logic [IdxWidth-1:0] idx_t;

   idx_t rr_q, rr_d;
   idx_t grant;
   idx_t head;
   logic any_valid;
   logic fifo_full, fifo_empty;
   logic req_fire, rsp_fire;

   // ---------------------------------------------------------------------------
   // Request arbitration: first valid port at or after the rr pointer. The
   // search looks only at in_valid_i and rr_q, never at out_ready_i, so the
   // winner and its payload stay put while the bank stalls.
   // ---------------------------------------------------------------------------
   always_comb begin
      logic        found;
      int unsigned idx;
      grant = rr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NumInPorts; i++) begin
         idx = (int'(rr_q) + i) % NumInPorts;
         if (!found && in_valid_i[idx]) begin
            found = 1'b1;
            grant = idx_t'(idx);
         end
      end
   end

   assign any_valid = |in_valid_i;

   // Outputs are forced low while reset is held: the FIFO is empty (not full)
   // in reset, so without this a valid input would leak through.
   assign out_valid_o = rst_ni && any_valid && !fifo_full;
   assign req_fire    = out_valid_o && out_ready_i;

   // Full blocks issue even when a pop happens this cycle, keeping out_ready_i
   // and in_ready_i from forming a combinational path through the FIFO.
   always_comb begin
      in_ready_o = '0;
      if (rst_ni && out_ready_i && !fifo_full) in_ready_o[grant] = 1'b1;
   end

   assign out_address_o = in_address_i[grant];
   assign out_amo_o     = in_amo_i[grant];
   assign out_write_o   = in_write_i[grant];
   assign out_wdata_o   = in_wdata_i[grant];
   assign out_be_o      = in_be_i[grant];
   assign out_meta_o    = in_meta_i[grant];

   // Pointer advances past the winner only when its request is taken, so a
   // stalled winner keeps the grant.
   assign rr_d = req_fire ? idx_t'(rr_next(int'(grant), NumInPorts)) : rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else         rr_q <= rr_d;
   end

   // ---------------------------------------------------------------------------
   // Port-ID FIFO: one entry per accepted request, popped per response.
   // ---------------------------------------------------------------------------
   tcdm_bank_req_arbiter_fifo #(
      .DataWidth (IdxWidth),
      .Depth     (RespFifoDepth)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (req_fire),
      .data_i  (grant),
      .pop_i   (rsp_fire),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ---------------------------------------------------------------------------
   // Response routing to the head port; data/meta are broadcast and qualified
   // by the per-port valid.
   // ---------------------------------------------------------------------------
   always_comb begin
      in_valid_o = '0;
      if (out_valid_i && !fifo_empty) in_valid_o[head] = 1'b1;
   end

   assign out_ready_o = !fifo_empty && in_ready_i[head];
   assign rsp_fire    = out_valid_i && out_ready_o;

   always_comb begin
      for (int unsigned p = 0; p < NumInPorts; p++) begin
         in_rdata_o[p] = out_rdata_i;
         in_meta_o[p]  = out_meta_i;
      end
   end

   // A response with nothing outstanding means the downstream broke the
   // one-response-per-request contract.
   resp_without_req_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) out_valid_i |-> !fifo_empty
   );

endmodule

// File: tb/tb_tcdm_bank_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcdm_bank_req_arbiter
//   Directed scenarios followed by random traffic. Expected values come from
//   a behavioural model: an rr index plus a queue of outstanding port IDs.
// -----------------------------------------------------------------------------
module tb_tcdm_bank_req_arbiter;

   localparam int N     = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready_o;
   logic [AW-1:0] in_address [N];
   logic [3:0]    in_amo     [N];
   logic [N-1:0]  in_write;
   logic [DW-1:0] in_wdata   [N];
   logic [BW-1:0] in_be      [N];
   logic          in_meta    [N];
   logic [N-1:0]  in_valid_o;
   logic [N-1:0]  in_ready_rsp;
   logic [DW-1:0] in_rdata_o [N];
   logic          in_meta_o  [N];
   logic          out_valid_o;
   logic          out_ready;
   logic [AW-1:0] out_address_o;
   logic [3:0]    out_amo_o;
   logic          out_write_o;
   logic [DW-1:0] out_wdata_o;
   logic [BW-1:0] out_be_o;
   logic          out_meta_o;
   logic          out_valid_rsp;
   logic          out_ready_o;
   logic [DW-1:0] out_rdata_rsp;
   logic          out_meta_rsp;

   tcdm_bank_req_arbiter #(
      .NumInPorts    (N),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .metadata_t    (logic),
      .RespFifoDepth (DEPTH)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready_o),
      .in_address_i  (in_address),
      .in_amo_i      (in_amo),
      .in_write_i    (in_write),
      .in_wdata_i    (in_wdata),
      .in_be_i       (in_be),
      .in_meta_i     (in_meta),
      .in_valid_o    (in_valid_o),
      .in_ready_i    (in_ready_rsp),
      .in_rdata_o    (in_rdata_o),
      .in_meta_o     (in_meta_o),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready),
      .out_address_o (out_address_o),
      .out_amo_o     (out_amo_o),
      .out_write_o   (out_write_o),
      .out_wdata_o   (out_wdata_o),
      .out_be_o      (out_be_o),
      .out_meta_o    (out_meta_o),
      .out_valid_i   (out_valid_rsp),
      .out_ready_o   (out_ready_o),
      .out_rdata_i   (out_rdata_rsp),
      .out_meta_i    (out_meta_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   int q[$];
   int rr;

   int vectors;
   int miscompares;

   // DUT outputs sampled in the last step, for scenario-specific checks
   logic [N-1:0]  snap_in_ready;
   logic [N-1:0]  snap_in_valid_o;
   logic          snap_out_valid;
   logic          snap_out_ready;
   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_rdata0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_payload();
      for (int p = 0; p < N; p++) begin
         in_address[p] = $urandom;
         in_amo[p]     = 4'($urandom);
         in_write[p]   = 1'($urandom);
         in_wdata[p]   = $urandom;
         in_be[p]      = BW'($urandom);
         in_meta[p]    = 1'($urandom);
      end
      out_rdata_rsp = $urandom;
      out_meta_rsp  = 1'($urandom);
   endtask

   // Respond whenever the model has something outstanding.
   task automatic rsp_auto();
      out_valid_rsp = (q.size() > 0);
   endtask

   task automatic enter_reset();
      rst_n = 1'b0;
      q.delete();
      rr = 0;
      out_valid_rsp = 1'b0;
   endtask

   // One clock cycle: predict, sample at negedge, compare, update model at
   // posedge, return 1 time unit after the edge for the next drive.
   task automatic step();
      int            g, h;
      bit            found, full, empty;
      logic [N-1:0]  e_in_ready, e_in_valid_o;
      logic          e_out_valid, e_out_ready;
      full  = (q.size() >= DEPTH);
      empty = (q.size() == 0);
      g     = rr;
      found = 0;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (rr + i) % N;
         if (!found && in_valid[idx]) begin
            found = 1;
            g     = idx;
         end
      end
      e_out_valid  = rst_n && (in_valid != '0) && !full;
      e_in_ready   = (rst_n && out_ready && !full) ? (N'(1) << g) : '0;
      h            = empty ? 0 : q[0];
      e_in_valid_o = (rst_n && out_valid_rsp && !empty) ? (N'(1) << h) : '0;
      e_out_ready  = rst_n && !empty && in_ready_rsp[h];

      @(negedge clk);
      snap_in_ready   = in_ready_o;
      snap_in_valid_o = in_valid_o;
      snap_out_valid  = out_valid_o;
      snap_out_ready  = out_ready_o;
      snap_addr       = out_address_o;
      snap_rdata0     = in_rdata_o[0];
      check("out_valid_o", out_valid_o, e_out_valid);
      check("in_ready_o",  in_ready_o,  e_in_ready);
      check("in_valid_o",  in_valid_o,  e_in_valid_o);
      check("out_ready_o", out_ready_o, e_out_ready);
      if (e_out_valid) begin
         check("out_address_o", out_address_o, in_address[g]);
         check("out_wdata_o",   out_wdata_o,   in_wdata[g]);
         check("out_ctrl_o", {out_amo_o, out_write_o, out_be_o, out_meta_o},
               {in_amo[g], in_write[g], in_be[g], in_meta[g]});
      end
      if (e_in_valid_o != '0) begin
         check("in_rdata_o", in_rdata_o[h], out_rdata_rsp);
         check("in_meta_o",  in_meta_o[h],  out_meta_rsp);
      end

      @(posedge clk);
      if (rst_n) begin
         if (out_valid_rsp && e_out_ready) void'(q.pop_front());
         if (e_out_valid && out_ready) begin
            q.push_back(g);
            rr = (g + 1) % N;
         end
      end
      #1;
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      in_valid     = '0;
      out_ready    = 1'b0;
      in_ready_rsp = '1;
      randomize_payload();
      enter_reset();

      // ---- reset state, with requests already pending
      in_valid = 4'b1111;
      step();
      check("rst_out_valid", snap_out_valid, 1'b0);
      check("rst_in_ready",  snap_in_ready,  4'b0000);
      step();
      rst_n = 1'b1;
      in_valid = '0;

      // ---- single port 0 load, response one cycle later
      in_valid  = 4'b0001;
      in_write  = '0;
      out_ready = 1'b1;
      step();
      in_valid = '0;
      out_rdata_rsp = 32'hCAFE_0123;
      rsp_auto();
      step();
      check("p0_in_valid_o", snap_in_valid_o, 4'b0001);
      check("p0_rdata",      snap_rdata0,     32'hCAFE_0123);
      out_valid_rsp = 1'b0;

      // ---- all ports valid, bank always ready: grants 0,1,2,3,0
      enter_reset();
      step();
      rst_n = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         randomize_payload();
         rsp_auto();
         step();
         check("grant_order", snap_in_ready, N'(1) << (k % N));
         if (k > 0) check("resp_order", snap_in_valid_o, N'(1) << ((k - 1) % N));
      end
      in_valid = '0;
      while (q.size() > 0) begin
         rsp_auto();
         step();
      end
      out_valid_rsp = 1'b0;

      // ---- stall with port 2 winning
      enter_reset();
      step();
      rst_n = 1'b1;
      in_valid = 4'b0001;
      step();
      in_valid = 4'b0010;
      rsp_auto();
      step();
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rsp_auto();
         step();
         check("stall_addr",     snap_addr,     in_address[2]);
         check("stall_in_ready", snap_in_ready, 4'b0000);
      end
      out_ready = 1'b1;
      rsp_auto();
      step();
      check("stall_release", snap_in_ready, 4'b0100);
      rsp_auto();
      step();
      check("after_stall", snap_in_ready, 4'b1000);
      in_valid = '0;
      while (q.size() > 0) begin
         rsp_auto();
         step();
      end
      out_valid_rsp = 1'b0;

      // ---- FIFO full: issue blocked, even on a same-cycle pop
      enter_reset();
      step();
      rst_n = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) step();
      step();
      check("full_out_valid", snap_out_valid, 1'b0);
      check("full_in_ready",  snap_in_ready,  4'b0000);
      out_valid_rsp = 1'b1;
      step();
      check("full_pop_out_valid", snap_out_valid,  1'b0);
      check("full_pop_in_valid",  snap_in_valid_o, 4'b0001);
      out_valid_rsp = 1'b0;
      step();
      check("full_resume", snap_out_valid, 1'b1);

      // ---- head port 1 not ready: response held
      enter_reset();
      step();
      rst_n = 1'b1;
      in_valid = 4'b0010;
      step();
      in_valid      = '0;
      out_valid_rsp = 1'b1;
      in_ready_rsp  = 4'b1101;
      for (int k = 0; k < 2; k++) begin
         step();
         check("hold_in_valid_o", snap_in_valid_o, 4'b0010);
         check("hold_out_ready",  snap_out_ready,  1'b0);
      end
      in_ready_rsp = 4'b1111;
      step();
      check("hold_release", snap_out_ready, 1'b1);
      out_valid_rsp = 1'b0;

      // ---- reset with 3 outstanding
      enter_reset();
      step();
      rst_n = 1'b1;
      in_valid = 4'b0111;
      for (int k = 0; k < 3; k++) step();
      enter_reset();
      in_valid = 4'b1111;
      step();
      check("midrst_out_valid", snap_out_valid, 1'b0);
      check("midrst_in_ready",  snap_in_ready,  4'b0000);
      check("midrst_in_valid",  snap_in_valid_o, 4'b0000);
      rst_n = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         step();
         check("midrst_refill", snap_out_valid, 1'b1);
      end
      step();
      check("midrst_full", snap_out_valid, 1'b0);

      // ---- random traffic
      enter_reset();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 500; k++) begin
         if (k == 250) enter_reset();
         else          rst_n = 1'b1;
         randomize_payload();
         in_valid      = N'($urandom);
         out_ready     = ($urandom_range(0, 3) != 0);
         in_ready_rsp  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
         out_valid_rsp = (q.size() > 0) && ($urandom_range(0, 3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
